pipe_hazard_ctrl: RTL

Central stall/flush sequencer for the 5-stage pipeline.
- Drives the stall and flush inputs of the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers, plus the PC hold.
- Detects load-use hazards and EX-stage redirects (branch/call/return).
- Runs an FSM for instruction- and data-memory wait states, with a data-memory timeout that halts the pipe and raises a sticky error.

---
 rtl/pipe_hazard_ctrl.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// ----------------
// Central stall/flush sequencer for the 5-stage pipeline. It drives the
// stall/flush controls of the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline
// registers plus the PC hold. It resolves load-use hazards and EX-stage
// redirects, and sequences instruction/data-memory wait states. A data-memory
// access that stays unfinished for too long freezes the pipe and sets a sticky
// error.
//
// Build option: define STALL_CNT_EN to build a 32-bit counter of pc_hold
// cycles on stall_cycles. When it is not defined, stall_cycles is tied to 0.
//
// Parameters
//   REG_AW   register-address width
//   TIMEOUT  max cycles a data access may stall before ERR (2..2^TO_W-1)
//   TO_W     timeout counter width
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   id_rs1/id_rs2, id_use_rs*   ID-stage source registers and their use flags
//   ex_is_load, ex_reg_dst      EX-stage load flag and destination register
//   ex_redirect                 EX resolved a taken branch/call/return
//   imem_ready                  fetch data valid this cycle
//   mem_req, mem_ready          data-memory request / completion
//   err_clr                     leaves the error state
//   pc_hold, stall_*, flush_*   pipeline controls (combinational)
//   mem_err                     sticky data-memory timeout flag (registered)
//   stall_cycles                pc_hold cycle count (0 unless STALL_CNT_EN)
//   dbg_state                   current FSM state (0 RUN, 1 DMEM_WAIT, 2 ERR)
//
// Handshake: mem_req is held by the MEM stage for the whole access. The access
// completes in the first cycle with mem_ready=1. If mem_req drops while the
// controller is waiting, that also counts as completion. A data stall exists
// exactly when mem_req=1 and mem_ready=0.

module pipe_hazard_ctrl #(
  parameter int REG_AW  = 4,
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_reg_dst,
  input  logic              ex_redirect,
  input  logic              imem_ready,
  input  logic              mem_req,
  input  logic              mem_ready,
  input  logic              err_clr,
  output logic              pc_hold,
  output logic              stall_if_id,
  output logic              flush_if_id,
  output logic              stall_id_ex,
  output logic              flush_id_ex,
  output logic              stall_ex_mem,
  output logic              flush_ex_mem,
  output logic              flush_mem_wb,
  output logic              mem_err,
  output logic [31:0]       stall_cycles,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DMEM_WAIT = 2'd1,
    ERR       = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [TO_W-1:0] to_cnt, to_cnt_nxt;
  logic            mem_err_nxt;

  logic dstall;
  logic lu;

  assign dstall = mem_req & ~mem_ready;

  // Register 0 is hard-wired, so a load targeting it never creates a hazard.
  assign lu = ex_is_load && (ex_reg_dst != '0) &&
              ((id_use_rs1 && (id_rs1 == ex_reg_dst)) ||
               (id_use_rs2 && (id_rs2 == ex_reg_dst)));

  assign dbg_state = state;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      to_cnt  <= '0;
      mem_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      to_cnt  <= to_cnt_nxt;
      mem_err <= mem_err_nxt;
    end
  end

  // Next-state logic. to_cnt starts at 1 on entry because the cycle spent in
  // RUN, when the stall was first seen, already counts as a wait cycle.
  always_comb begin
    state_nxt   = state;
    to_cnt_nxt  = to_cnt;
    mem_err_nxt = mem_err;
    case (state)
      RUN: begin
        if (dstall) begin
          state_nxt  = DMEM_WAIT;
          to_cnt_nxt = TO_W'(1);
        end
      end
      DMEM_WAIT: begin
        if (!dstall) begin
          state_nxt  = RUN;
          to_cnt_nxt = '0;
        end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
          state_nxt   = ERR;
          mem_err_nxt = 1'b1;
        end else begin
          to_cnt_nxt = to_cnt + TO_W'(1);
        end
      end
      ERR: begin
        if (err_clr) begin
          state_nxt   = RUN;
          to_cnt_nxt  = '0;
          mem_err_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt   = RUN;
        to_cnt_nxt  = '0;
        mem_err_nxt = 1'b0;
      end
    endcase
  end

  // Output logic. RUN and DMEM_WAIT share one priority chain. While waiting,
  // dstall is still 1 and selects the hold. In the completion cycle dstall is 0,
  // so the remaining RUN priorities apply. The outputs are gated with rst_n so
  // the pipe sees no control while reset is asserted.
  always_comb begin
    pc_hold      = 1'b0;
    stall_if_id  = 1'b0;
    flush_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    flush_id_ex  = 1'b0;
    stall_ex_mem = 1'b0;
    flush_ex_mem = 1'b0;
    flush_mem_wb = 1'b0;
    if (rst_n) begin
      if (state == ERR) begin
        // Freeze the front of the pipe and drop the faulting access.
        // EX_MEM gets both stall and flush; flush wins inside that register.
        pc_hold      = 1'b1;
        stall_if_id  = 1'b1;
        stall_id_ex  = 1'b1;
        stall_ex_mem = 1'b1;
        flush_ex_mem = 1'b1;
        flush_mem_wb = 1'b1;
      end else if (dstall) begin
        // The redirect is ignored here. EX is held, so it is presented again.
        pc_hold      = 1'b1;
        stall_if_id  = 1'b1;
        stall_id_ex  = 1'b1;
        stall_ex_mem = 1'b1;
        flush_mem_wb = 1'b1;
      end else if (ex_redirect) begin
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end else if (lu) begin
        pc_hold     = 1'b1;
        stall_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end else if (!imem_ready) begin
        pc_hold     = 1'b1;
        flush_if_id = 1'b1;
      end
    end
  end

`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (pc_hold) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule
